// File: rtl/button_debounce.sv
// Push-button conditioner: per-channel 2-flop synchroniser and tick-sampled bounce filter.
// One shared prescaler produces the slow tick used as the filter clock enable.
module button_debounce #(
    parameter int WIDTH        = 2,
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] btn_in,
    output logic             tick,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release
);

    localparam int unsigned WIDTH_U = WIDTH;
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W = $clog2(STABLE_TICKS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    localparam logic [0:0] ST_STABLE  = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;

    logic [WIDTH-1:0] s1_q, s2_q;

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] press_q, press_d;
    logic [WIDTH-1:0] release_q, release_d;
    logic [WIDTH-1:0] state_w;

    always_comb begin
        tick_d = (div_q == DIV_LAST);
        div_d  = tick_d ? '0 : div_q + DIV_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= btn_in;
            s2_q <= s1_q;
        end
    end

    // The registered tick is the enable, so acceptance lands on the edge after tick_q is seen high.
    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        state_w   = '0;
        for (int unsigned i = 0; i < WIDTH_U; i++) begin
            cnt_d[i]   = cnt_q[i];
            state_w[i] = (s2_q[i] != level_q[i]) ? ST_PENDING : ST_STABLE;
            case (state_w[i])
                ST_STABLE: cnt_d[i] = '0;
                default: begin
                    if (tick_q) begin
                        if (cnt_q[i] == CNT_LAST) begin
                            level_d[i]   = s2_q[i];
                            cnt_d[i]     = '0;
                            press_d[i]   = s2_q[i];
                            release_d[i] = ~s2_q[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < WIDTH_U; i++) begin
                cnt_q[i] <= '0;
            end
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            for (int unsigned i = 0; i < WIDTH_U; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign tick        = tick_q;
    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: two instances (window 3 and window 1 ticks) share stimulus;
// a timestamp-based reference model feeds per-instance expectation queues drained by a monitor.
module tb_button_debounce;

    localparam int TD = 4;

    logic       clk;
    logic       rst;
    logic [1:0] btn_in;

    logic       tick0, tick1;
    logic [1:0] lvl0, lvl1, pr0, pr1, rl0, rl1;

    button_debounce #(.WIDTH(2), .TICK_DIV(TD), .STABLE_TICKS(3)) u_dut0 (
        .clk(clk), .rst(rst), .btn_in(btn_in), .tick(tick0),
        .btn_level(lvl0), .btn_press(pr0), .btn_release(rl0)
    );

    button_debounce #(.WIDTH(2), .TICK_DIV(TD), .STABLE_TICKS(1)) u_dut1 (
        .clk(clk), .rst(rst), .btn_in(btn_in), .tick(tick1),
        .btn_level(lvl1), .btn_press(pr1), .btn_release(rl1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    // A pending change is accepted on a tick once STABLE_TICKS-1 earlier ticks have
    // elapsed since the last edge at which the synchronised input matched the level.
    logic [6:0] q0[$];
    logic [6:0] q1[$];

    int unsigned m_cyc  [2];
    int unsigned m_tot  [2];
    int unsigned m_mark [2][2];
    bit [1:0]    m_sh1  [2];
    bit [1:0]    m_sh2  [2];
    bit [1:0]    m_lvl  [2];
    bit          m_tk   [2];
    bit [1:0]    m_pr   [2];
    bit [1:0]    m_rl   [2];

    function automatic int unsigned st_of(input int m);
        return (m == 0) ? 3 : 1;
    endfunction

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            m_pr[m] = '0;
            m_rl[m] = '0;
            if (rst) begin
                m_cyc[m] = 0; m_tot[m] = 0; m_tk[m] = 1'b0;
                m_sh1[m] = '0; m_sh2[m] = '0; m_lvl[m] = '0;
                m_mark[m][0] = 0; m_mark[m][1] = 0;
            end else begin
                for (int c = 0; c < 2; c++) begin
                    if (m_sh2[m][c] == m_lvl[m][c]) begin
                        m_mark[m][c] = m_tot[m] + (m_tk[m] ? 1 : 0);
                    end else if (m_tk[m] && (m_tot[m] - m_mark[m][c] >= st_of(m) - 1)) begin
                        m_lvl[m][c] = m_sh2[m][c];
                        if (m_sh2[m][c]) m_pr[m][c] = 1'b1;
                        else             m_rl[m][c] = 1'b1;
                        m_mark[m][c] = m_tot[m] + 1;
                    end
                end
                m_tot[m] = m_tot[m] + (m_tk[m] ? 1 : 0);
                m_sh2[m] = m_sh1[m];
                m_sh1[m] = btn_in;
                m_cyc[m] = m_cyc[m] + 1;
                m_tk[m]  = (m_cyc[m] % TD == 0);
            end
            if (m == 0) q0.push_back({m_tk[m], m_lvl[m], m_pr[m], m_rl[m]});
            else        q1.push_back({m_tk[m], m_lvl[m], m_pr[m], m_rl[m]});
        end
    end

    // ---------------- monitor ----------------
    int pcnt0 [2];
    int rcnt0 [2];

    initial begin
        pcnt0[0] = 0; pcnt0[1] = 0; rcnt0[0] = 0; rcnt0[1] = 0;
    end

    always @(negedge clk) begin
        logic [6:0] e;
        logic [6:0] a;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            a = {tick0, lvl0, pr0, rl0};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL dut0_outputs t=%0t {tick,level,press,release} got=%b expected=%b", $time, a, e);
            end
            for (int c = 0; c < 2; c++) begin
                if (pr0[c] === 1'b1) pcnt0[c]++;
                if (rl0[c] === 1'b1) rcnt0[c]++;
            end
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            a = {tick1, lvl1, pr1, rl1};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL dut1_outputs t=%0t {tick,level,press,release} got=%b expected=%b", $time, a, e);
            end
        end
    end

    // ---------------- directed checks ----------------
    task automatic chk(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s got=%0d expected_range=[%0d,%0d]", name, act, lo, hi);
        end
    endtask

    // first edge (1-based) at which each pulse appears: [inst][0=press,1=release][ch]
    int fp [2][2][2];
    int ft;

    task automatic step_watch(input int limit);
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 2; k++)
                for (int c = 0; c < 2; c++)
                    fp[i][k][c] = -1;
        ft = -1;
        for (int e = 1; e <= limit; e++) begin
            @(negedge clk);
            if (ft < 0 && tick0 === 1'b1) ft = e;
            for (int c = 0; c < 2; c++) begin
                if (fp[0][0][c] < 0 && pr0[c] === 1'b1) fp[0][0][c] = e;
                if (fp[0][1][c] < 0 && rl0[c] === 1'b1) fp[0][1][c] = e;
                if (fp[1][0][c] < 0 && pr1[c] === 1'b1) fp[1][0][c] = e;
                if (fp[1][1][c] < 0 && rl1[c] === 1'b1) fp[1][1][c] = e;
            end
        end
    endtask

    int snap_p, snap_r;

    initial begin
        rst    = 1'b1;
        btn_in = 2'b11;
        repeat (3) @(negedge clk);

        // reset release: inputs dropped so later scenarios start from idle
        rst    = 1'b0;
        btn_in = 2'b00;
        @(negedge clk);
        chk("post_reset_outputs", int'({tick0, lvl0, pr0, rl0}), 0, 0);
        step_watch(6);
        chk("first_tick_edge", ft + 1, 4, 4);
        repeat (4) @(negedge clk);

        // clean press on channel 0, both window sizes
        snap_r = rcnt0[0];
        btn_in = 2'b01;
        step_watch(20);
        chk("clean_press_latency", fp[0][0][0], 11, 14);
        chk("clean_press_count", pcnt0[0], 1, 1);
        chk("clean_press_no_release", rcnt0[0] - snap_r, 0, 0);
        chk("clean_press_level", int'(lvl0[0]), 1, 1);
        chk("single_tick_latency", fp[1][0][0], 3, 6);

        // bounce on channel 1: 3-cycle toggles never survive the window
        snap_p = pcnt0[1];
        for (int i = 0; i < 13; i++) begin
            btn_in[1] = ~btn_in[1];
            repeat (3) @(negedge clk);
        end
        chk("bounce_no_pulse", pcnt0[1] - snap_p, 0, 0);
        chk("bounce_final_input", int'(btn_in[1]), 1, 1);
        step_watch(20);
        chk("bounce_press_latency", fp[0][0][1], 11, 14);
        chk("bounce_press_count", pcnt0[1] - snap_p, 1, 1);

        // simultaneous release on both channels
        btn_in = 2'b00;
        step_watch(20);
        chk("release_ch0_latency", fp[0][1][0], 11, 14);
        chk("release_same_cycle", fp[0][1][1], fp[0][1][0], fp[0][1][0]);
        chk("release_level_zero", int'(lvl0), 0, 0);

        // reset while pending discards progress
        snap_p = pcnt0[0];
        btn_in = 2'b01;
        repeat (8) @(negedge clk);
        chk("pending_no_early_press", pcnt0[0] - snap_p, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step_watch(20);
        chk("post_reset_press_latency", fp[0][0][0], 10, 13);
        chk("post_reset_press_count", pcnt0[0] - snap_p, 1, 1);

        // random holds with occasional reset, checked by the model
        for (int i = 0; i < 250; i++) begin
            btn_in = 2'($urandom);
            rst    = ($urandom_range(0, 39) == 0);
            @(negedge clk);
            rst = 1'b0;
            repeat ($urandom_range(0, 23)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
# button_debounce

Conditions the raw push-button inputs before they reach the `edge_detect` instances and the combination lock. The block synchronises each asynchronous button into the 100 MHz domain and filters contact bounce against a shared slow tick. It produces a clean level, one-cycle press/release pulses, and the slow tick itself, which the lock and edge detectors use as their clock enable. One instance serves both buttons, placed between the `BUT` pins and the edge-detect stage.

## Interface

Parameters:
- `WIDTH`, 2: number of independent button channels.
- `TICK_DIV`, 100000: `clk` cycles per slow tick (1 ms at 100 MHz); legal range ≥ 2.
- `STABLE_TICKS`, 10: consecutive ticks a new input value must persist before it is accepted; legal range ≥ 1.

Ports:
- `clk` input 1: 100 MHz system clock. Single clock domain; all flops are on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `btn_in` input WIDTH: raw, asynchronous button levels, active-high.
- `tick` output 1: one-`clk`-cycle strobe, once every `TICK_DIV` cycles.
- `btn_level` output WIDTH: debounced button level.
- `btn_press` output WIDTH: one-cycle pulse when `btn_level[i]` goes 0→1.
- `btn_release` output WIDTH: one-cycle pulse when `btn_level[i]` goes 1→0.

## Operation

- **Prescaler:** counter `div` counts 0..`TICK_DIV`-1 and wraps to 0.
  - `tick` is registered; it is 1 in the cycle after `div` == `TICK_DIV`-1 and is never high in two consecutive cycles.
  - Counter width is `$clog2(TICK_DIV)`.
- **Synchroniser:** each channel has a 2-flop chain, `btn_in` → `s1` → `s2`. Only `s2` is used downstream.
- **Per-channel filter:** counter `cnt`, width `$clog2(STABLE_TICKS+1)`, with two states.
  - STABLE (`s2` == `btn_level`): `cnt` is forced to 0 every cycle, regardless of `tick`.
  - PENDING (`s2` != `btn_level`): on each cycle with `tick`=1, `cnt` increments.
  - Acceptance: when `tick`=1 and `cnt` == `STABLE_TICKS`-1, then on that same edge `btn_level` ← `s2`, `cnt` ← 0, and the matching press or release pulse is set to 1.
  - Bounce back: if `s2` returns to equal `btn_level` before acceptance, the channel goes back to STABLE and `cnt` clears. No output changes.
- **Pulses:** `btn_press`/`btn_release` are registered. They are high for exactly one cycle, coincident with the first cycle of the new `btn_level`. They default to 0 on every other cycle.
- **Channel independence:** channels share only the `div`/`tick` counter. Simultaneous acceptance on several channels in the same cycle is legal, and each channel pulses independently.
- **Reset values** (all take effect on the edge where `rst`=1):
  - `div`=0, `tick`=0.
  - `s1`=`s2`=0.
  - `cnt`=0.
  - `btn_level`=0, `btn_press`=0, `btn_release`=0.
- **Reset mid-operation:** a reset during PENDING discards progress. After reset deassertion, a button held high must again satisfy the full `STABLE_TICKS` window and then produces a `btn_press` pulse.

## Timing

- `tick` period is exactly `TICK_DIV` cycles. The first `tick` occurs `TICK_DIV` cycles after the first edge with `rst`=0.
- Synchroniser latency is 2 cycles from a `btn_in` change to `s2`.
- Acceptance latency from `s2` changing:
  - Minimum: (`STABLE_TICKS`-1)·`TICK_DIV`+1 cycles.
  - Maximum: `STABLE_TICKS`·`TICK_DIV` cycles.
  - `btn_level` and the pulse update on the edge of the `STABLE_TICKS`-th tick seen in PENDING.
- **Glitch rejection:** a glitch shorter than (`STABLE_TICKS`-1)·`TICK_DIV` cycles never changes `btn_level`.
- **`STABLE_TICKS`=1:** a change is accepted on the first `tick` after `s2` differs.
- **No extra latency:** there is no combinational path from `btn_in` to any output, and no pipelining beyond what is stated above.

## Test plan

All scenarios use `TICK_DIV`=4 and `STABLE_TICKS`=3 unless noted.

- **Reset:** hold `rst` 3 cycles with `btn_in`=2'b11 → all outputs 0 during reset and on the first cycle after release. `tick` first asserts 4 cycles after the first cycle with `rst`=0.
- **Clean press:** `btn_in[0]` 0→1 and held → `btn_press[0]` is exactly one cycle high and `btn_level[0]`=1. This occurs between 9 and 12 cycles after `s2[0]` rises (2 cycles after `btn_in`). `btn_release` stays 0.
- **Bounce:** toggle `btn_in[1]` every 3 cycles for 40 cycles, then hold 1 → no pulse during toggling. Exactly one `btn_press[1]` appears within 12 cycles of `s2[1]` settling.
- **Release and simultaneous channels:** with both levels at 1, drop both `btn_in` bits on the same cycle → `btn_release`=2'b11 in a single cycle and `btn_level`=2'b00 thereafter.
- **Reset mid-PENDING:** hold `btn_in[0]`=1 for 2 ticks, pulse `rst` for 1 cycle, keep holding → no pulse before reset. `btn_press[0]` arrives a full window (9–12 cycles after `s2[0]` re-syncs) after reset.
- **Single-tick window:** with `STABLE_TICKS`=1, step `btn_in[0]` 0→1 → `btn_press[0]` on the first `tick` at least 2 cycles after the step, and never later than 4 cycles after `s2[0]` changes.
